// File: rtl/traffic_phase_scheduler_if.sv
// Interface bundling the scheduler's request inputs and signal-head outputs.
//   sensor_side : side-road vehicle present (level)
//   ped_req     : pedestrian push-button (pulse)
//   light_main  : main head code, 00 red / 01 yellow / 10 green
//   light_side  : side head code, same encoding
//   walk        : pedestrian walk lamp
//   ped_wait    : pedestrian request latched, not yet served
//   phase       : current scheduler state code
// master drives the requests and observes the lights; slave is the scheduler.
interface traffic_phase_scheduler_if;
  logic       sensor_side;
  logic       ped_req;
  logic [1:0] light_main;
  logic [1:0] light_side;
  logic       walk;
  logic       ped_wait;
  logic [2:0] phase;

  modport master (
    output sensor_side, ped_req,
    input  light_main, light_side, walk, ped_wait, phase
  );

  modport slave (
    input  sensor_side, ped_req,
    output light_main, light_side, walk, ped_wait, phase
  );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Intersection phase scheduler: sequences main/side signal heads and an
// optional pedestrian walk phase, arbitrating side sensor vs. push-button,
// with every dwell timed off a prescaled tick.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : traffic_phase_scheduler_if.slave (requests in, lights/status out)
// Build option: define TRAFFIC_PED_EN to implement the pedestrian latch,
// PED_WALK state and walk lamp; otherwise ped_req is ignored and
// walk/ped_wait stay 0.
module traffic_phase_scheduler #(
  parameter int unsigned TICK_DIV  = 1000,
  parameter int unsigned MIN_GREEN = 8,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned SIDE_T    = 6,
  parameter int unsigned WALK_T    = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  traffic_phase_scheduler_if.slave  bus
);

  localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned M1   = (MIN_GREEN > YELLOW_T) ? MIN_GREEN : YELLOW_T;
  localparam int unsigned M2   = (M1 > ALLRED_T) ? M1 : ALLRED_T;
  localparam int unsigned M3   = (M2 > SIDE_T) ? M2 : SIDE_T;
  localparam int unsigned TMAX = (M3 > WALK_T) ? M3 : WALK_T;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALLRED_1    = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALLRED_2    = 3'd5,
    PED_WALK    = 3'd6
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   presc, presc_nxt;
  logic [TW-1:0]   tcnt, tcnt_nxt;
  logic            side_pend, side_pend_nxt;
  logic            ped_pend, ped_pend_nxt;
  logic            tick;
  logic            side_set, ped_set, req_any, green_done;
  logic [1:0]      main_nxt, side_nxt;
  logic            walk_nxt;

`ifndef TRAFFIC_PED_EN
  logic ped_unused;
  assign ped_unused = bus.ped_req;
`endif

  // State, timers, request latches and registered head outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= MAIN_GREEN;
      presc          <= '0;
      tcnt           <= '0;
      side_pend      <= 1'b0;
      ped_pend       <= 1'b0;
      bus.light_main <= LIGHT_GREEN;
      bus.light_side <= LIGHT_RED;
      bus.walk       <= 1'b0;
      bus.ped_wait   <= 1'b0;
      bus.phase      <= 3'd0;
    end else begin
      state          <= state_nxt;
      presc          <= presc_nxt;
      tcnt           <= tcnt_nxt;
      side_pend      <= side_pend_nxt;
      ped_pend       <= ped_pend_nxt;
      bus.light_main <= main_nxt;
      bus.light_side <= side_nxt;
      bus.walk       <= walk_nxt;
      bus.ped_wait   <= ped_pend_nxt;
      bus.phase      <= state_nxt;
    end
  end

  // Next-state, timer, latch and output decode
  always_comb begin
    state_nxt     = state;
    presc_nxt     = presc;
    tcnt_nxt      = tcnt;
    side_pend_nxt = side_pend;
    ped_pend_nxt  = 1'b0;
    main_nxt      = LIGHT_RED;
    side_nxt      = LIGHT_RED;
    walk_nxt      = 1'b0;
    ped_set       = 1'b0;

    tick     = (presc == PW'(TICK_DIV - 1));
    side_set = bus.sensor_side && (state != SIDE_GREEN);
`ifdef TRAFFIC_PED_EN
    ped_set  = bus.ped_req && (state != PED_WALK);
`endif
    // A request arriving this clock may already end main green
    req_any    = side_pend || side_set || ped_pend || ped_set;
    green_done = (tcnt == TW'(MIN_GREEN)) ||
                 (tick && (tcnt == TW'(MIN_GREEN - 1)));

    case (state)
      MAIN_GREEN:  if (req_any && green_done) state_nxt = MAIN_YELLOW;
      MAIN_YELLOW: if (tick && tcnt == TW'(YELLOW_T - 1)) state_nxt = ALLRED_1;
      ALLRED_1: begin
        if (tick && tcnt == TW'(ALLRED_T - 1)) begin
`ifdef TRAFFIC_PED_EN
          state_nxt = side_pend ? SIDE_GREEN : PED_WALK;
`else
          state_nxt = side_pend ? SIDE_GREEN : MAIN_GREEN;
`endif
        end
      end
      SIDE_GREEN:  if (tick && tcnt == TW'(SIDE_T - 1))   state_nxt = SIDE_YELLOW;
      SIDE_YELLOW: if (tick && tcnt == TW'(YELLOW_T - 1)) state_nxt = ALLRED_2;
      ALLRED_2: begin
        if (tick && tcnt == TW'(ALLRED_T - 1))
          state_nxt = ped_pend ? PED_WALK : MAIN_GREEN;
      end
`ifdef TRAFFIC_PED_EN
      PED_WALK:    if (tick && tcnt == TW'(WALK_T - 1))   state_nxt = MAIN_GREEN;
`endif
      default:     state_nxt = MAIN_GREEN;
    endcase

    // Timers restart on every state entry; tick count saturates in main green
    if (state_nxt != state) begin
      presc_nxt = '0;
      tcnt_nxt  = '0;
    end else begin
      presc_nxt = tick ? '0 : presc + 1'b1;
      if (tick && !(state == MAIN_GREEN && tcnt == TW'(MIN_GREEN)))
        tcnt_nxt = tcnt + 1'b1;
    end

    // Entry into the serving state wins over a same-clock set
    side_pend_nxt = (state_nxt == SIDE_GREEN && state != SIDE_GREEN) ?
                    1'b0 : (side_pend || side_set);
`ifdef TRAFFIC_PED_EN
    ped_pend_nxt  = (state_nxt == PED_WALK && state != PED_WALK) ?
                    1'b0 : (ped_pend || ped_set);
`endif

    case (state_nxt)
      MAIN_GREEN:  main_nxt = LIGHT_GREEN;
      MAIN_YELLOW: main_nxt = LIGHT_YELLOW;
      SIDE_GREEN:  side_nxt = LIGHT_GREEN;
      SIDE_YELLOW: side_nxt = LIGHT_YELLOW;
`ifdef TRAFFIC_PED_EN
      PED_WALK:    walk_nxt = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler with short test-plan timing.
module tb_traffic_phase_scheduler;

  logic clk = 1'b0;
  logic reset;
  logic armed = 1'b0;
  int   checks = 0;
  int   errors = 0;

  traffic_phase_scheduler_if bus();

  traffic_phase_scheduler #(
    .TICK_DIV(2), .MIN_GREEN(4), .YELLOW_T(2),
    .ALLRED_T(1), .SIDE_T(3), .WALK_T(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Safety invariant watched on every cycle once the design is out of reset
  always @(negedge clk) begin
    if (armed) begin
      checks++;
      if ((bus.light_main != 2'b00 && bus.light_side != 2'b00) ||
          (bus.walk && (bus.light_main != 2'b00 || bus.light_side != 2'b00)) ||
          bus.light_main == 2'b11 || bus.light_side == 2'b11) begin
        errors++;
        $display("FAIL safety t=%0t main=%b side=%b walk=%b", $time,
                 bus.light_main, bus.light_side, bus.walk);
      end
    end
  end

  task automatic step;
    @(negedge clk);
  endtask

  // Returns at the negedge inside cycle 0
  task automatic do_reset;
    bus.sensor_side = 1'b0;
    bus.ped_req     = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    armed = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (bus.phase !== 3'd0)
      begin errors++; $display("FAIL rst_phase got %0d want 0", bus.phase); end
    checks++; if (bus.light_main !== 2'b10)
      begin errors++; $display("FAIL rst_main got %b want 10", bus.light_main); end
    checks++; if (bus.light_side !== 2'b00)
      begin errors++; $display("FAIL rst_side got %b want 00", bus.light_side); end
    checks++; if (bus.walk !== 1'b0)
      begin errors++; $display("FAIL rst_walk got %b want 0", bus.walk); end
    checks++; if (bus.ped_wait !== 1'b0)
      begin errors++; $display("FAIL rst_ped_wait got %b want 0", bus.ped_wait); end
  endtask

  task automatic test_idle;
    do_reset();
    for (int c = 0; c < 100; c++) begin
      checks++;
      if (bus.phase !== 3'd0 || bus.light_main !== 2'b10 || bus.light_side !== 2'b00) begin
        errors++;
        $display("FAIL idle c=%0d got phase=%0d main=%b side=%b want 0/10/00",
                 c, bus.phase, bus.light_main, bus.light_side);
      end
      step();
    end
  endtask

  task automatic test_side;
    logic [2:0] exp;
    do_reset();
    bus.sensor_side = 1'b1;
    for (int c = 0; c < 30; c++) begin
      exp = (c < 8)  ? 3'd0 : (c < 12) ? 3'd1 : (c < 14) ? 3'd2 :
            (c < 20) ? 3'd3 : (c < 24) ? 3'd4 : (c < 26) ? 3'd5 : 3'd0;
      checks++;
      if (bus.phase !== exp) begin
        errors++; $display("FAIL side_phase c=%0d got %0d want %0d", c, bus.phase, exp);
      end
      if (c == 8) begin
        checks++; if (bus.light_main !== 2'b01)
          begin errors++; $display("FAIL side_main_yel got %b want 01", bus.light_main); end
      end
      if (c == 14) begin
        checks++; if (bus.light_side !== 2'b10 || bus.light_main !== 2'b00)
          begin errors++; $display("FAIL side_green got main=%b side=%b want 00/10",
                                   bus.light_main, bus.light_side); end
      end
      if (c == 20) begin
        checks++; if (bus.light_side !== 2'b01)
          begin errors++; $display("FAIL side_yel got %b want 01", bus.light_side); end
      end
      step();
    end
    bus.sensor_side = 1'b0;
  endtask

  task automatic test_both;
    logic [2:0] exp;
    logic       exp_pw;
    do_reset();
    bus.sensor_side = 1'b1;
    bus.ped_req     = 1'b1;
    for (int c = 0; c < 36; c++) begin
`ifdef TRAFFIC_PED_EN
      exp = (c < 8)  ? 3'd0 : (c < 12) ? 3'd1 : (c < 14) ? 3'd2 :
            (c < 20) ? 3'd3 : (c < 24) ? 3'd4 : (c < 26) ? 3'd5 :
            (c < 30) ? 3'd6 : 3'd0;
      exp_pw = (c >= 1 && c < 26);
`else
      exp = (c < 8)  ? 3'd0 : (c < 12) ? 3'd1 : (c < 14) ? 3'd2 :
            (c < 20) ? 3'd3 : (c < 24) ? 3'd4 : (c < 26) ? 3'd5 : 3'd0;
      exp_pw = 1'b0;
`endif
      checks++;
      if (bus.phase !== exp) begin
        errors++; $display("FAIL both_phase c=%0d got %0d want %0d", c, bus.phase, exp);
      end
      checks++;
      if (bus.ped_wait !== exp_pw || bus.walk !== (exp == 3'd6)) begin
        errors++; $display("FAIL both_ped c=%0d got wait=%b walk=%b want %b/%b",
                           c, bus.ped_wait, bus.walk, exp_pw, exp == 3'd6);
      end
      step();
      bus.sensor_side = 1'b0;
      bus.ped_req     = 1'b0;
    end
  endtask

`ifdef TRAFFIC_PED_EN
  task automatic test_ped;
    logic [2:0] exp;
    do_reset();
    for (int c = 0; c < 36; c++) begin
      exp = (c < 21) ? 3'd0 : (c < 25) ? 3'd1 : (c < 27) ? 3'd2 :
            (c < 31) ? 3'd6 : 3'd0;
      checks++;
      if (bus.phase !== exp) begin
        errors++; $display("FAIL ped_phase c=%0d got %0d want %0d", c, bus.phase, exp);
      end
      checks++;
      if (bus.walk !== (exp == 3'd6) || bus.ped_wait !== (c >= 21 && c < 27)) begin
        errors++; $display("FAIL ped_lamps c=%0d got walk=%b wait=%b", c, bus.walk, bus.ped_wait);
      end
      bus.ped_req = (c == 20);
      step();
    end
    bus.ped_req = 1'b0;
  endtask
`else
  task automatic test_no_ped;
    do_reset();
    for (int c = 0; c < 60; c++) begin
      checks++;
      if (bus.phase !== 3'd0 || bus.walk !== 1'b0 || bus.ped_wait !== 1'b0) begin
        errors++; $display("FAIL no_ped c=%0d got phase=%0d walk=%b wait=%b want 0/0/0",
                           c, bus.phase, bus.walk, bus.ped_wait);
      end
      bus.ped_req = (c == 20);
      step();
    end
    bus.ped_req = 1'b0;
  endtask
`endif

  task automatic test_reset_mid;
    do_reset();
    bus.sensor_side = 1'b1;
    for (int c = 0; c < 15; c++) begin
      step();
      bus.sensor_side = 1'b0;
      bus.ped_req     = (c == 9);
    end
    bus.ped_req = 1'b0;
    checks++; if (bus.phase !== 3'd3)
      begin errors++; $display("FAIL mid_pre got %0d want 3", bus.phase); end
    reset = 1'b1;
    step();
    checks++; if (bus.phase !== 3'd0)
      begin errors++; $display("FAIL mid_phase got %0d want 0", bus.phase); end
    checks++; if (bus.light_side !== 2'b00 || bus.light_main !== 2'b10)
      begin errors++; $display("FAIL mid_lights got main=%b side=%b want 10/00",
                               bus.light_main, bus.light_side); end
    checks++; if (bus.ped_wait !== 1'b0)
      begin errors++; $display("FAIL mid_ped_wait got %b want 0", bus.ped_wait); end
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      checks++;
      if (bus.phase !== 3'd0) begin
        errors++; $display("FAIL mid_lost c=%0d got %0d want 0", c, bus.phase);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.sensor_side = 1'b0;
    bus.ped_req     = 1'b0;
    test_reset();
    test_idle();
    test_side();
    test_both();
`ifdef TRAFFIC_PED_EN
    test_ped();
`else
    test_no_ped();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
